// File: rtl/nios2_mult_pipe_cell.sv
// Pipelined Nios II integer multiplier (mul / mulxss / mulxsu / mulxuu).
// Stage 1 registers four unsigned HALF_W x HALF_W partial products plus the
// signed-correction term. Stage 2 sums them into the full 2*DATA_W product.
// Any extra stages carry that product forward. The last stage registers the
// selected half straight onto M_result.
//
// Handshake: E_valid qualifies E_src1/E_src2/E_mode on a clock edge with
// M_en=1. There is no ready: every enabled edge accepts one operation or one
// bubble. M_valid qualifies M_result. M_en=0 freezes every register.
module nios2_mult_pipe_cell #(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic [1:0]        E_mode,
    input  logic              E_valid,
    input  logic              M_en,
    output logic [DATA_W-1:0] M_result,
    output logic              M_valid,
    output logic              M_busy
);

    localparam int HALF_W = DATA_W / 2;
    localparam int PROD_W = 2 * DATA_W;

    // Operand halves feeding the partial-product multipliers
    logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
    assign a_lo = E_src1[HALF_W-1:0];
    assign a_hi = E_src1[DATA_W-1:HALF_W];
    assign b_lo = E_src2[HALF_W-1:0];
    assign b_hi = E_src2[DATA_W-1:HALF_W];

    // A is signed for mulxss/mulxsu; B is signed only for mulxss.
    // A negative signed operand contributes -(other operand) << DATA_W.
    logic              a_neg_sel, b_neg_sel;
    logic [DATA_W-1:0] corr_d;
    assign a_neg_sel = E_src1[DATA_W-1] & ((E_mode == 2'b01) | (E_mode == 2'b10));
    assign b_neg_sel = E_src2[DATA_W-1] & (E_mode == 2'b01);
    assign corr_d    = (a_neg_sel ? E_src2 : '0) + (b_neg_sel ? E_src1 : '0);

    // Stage 1 registers
    logic [DATA_W-1:0] s1_pp_ll, s1_pp_lh, s1_pp_hl, s1_pp_hh, s1_corr;
    logic [1:0]        s1_mode;
    logic              s1_valid;

    // Stage 1: register partial products, correction term, mode and valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pp_ll <= '0;
            s1_pp_lh <= '0;
            s1_pp_hl <= '0;
            s1_pp_hh <= '0;
            s1_corr  <= '0;
            s1_mode  <= 2'b00;
            s1_valid <= 1'b0;
        end else if (M_en) begin
            s1_pp_ll <= DATA_W'(a_lo) * DATA_W'(b_lo);
            s1_pp_lh <= DATA_W'(a_lo) * DATA_W'(b_hi);
            s1_pp_hl <= DATA_W'(a_hi) * DATA_W'(b_lo);
            s1_pp_hh <= DATA_W'(a_hi) * DATA_W'(b_hi);
            s1_corr  <= corr_d;
            s1_mode  <= E_mode;
            s1_valid <= E_valid;
        end
    end

    // Full product modulo 2^PROD_W; the correction only touches the high half
    logic [PROD_W-1:0] sum_full;
    assign sum_full = PROD_W'(s1_pp_ll)
                    + (PROD_W'(s1_pp_lh) << HALF_W)
                    + (PROD_W'(s1_pp_hl) << HALF_W)
                    + (PROD_W'(s1_pp_hh) << DATA_W)
                    - (PROD_W'(s1_corr)  << DATA_W);

    // Source of the final output stage
    logic [PROD_W-1:0] fin_prod;
    logic [1:0]        fin_mode;
    logic              fin_valid;
    logic              mid_busy;

    generate
        if (PIPE_STAGES == 2) begin : g_direct
            assign fin_prod  = sum_full;
            assign fin_mode  = s1_mode;
            assign fin_valid = s1_valid;
            assign mid_busy  = 1'b0;
        end else begin : g_mid
            localparam int N_MID = PIPE_STAGES - 2;
            logic [PROD_W-1:0] prod_q [N_MID];
            logic [1:0]        mode_q [N_MID];
            logic [N_MID-1:0]  valid_q;

            // Stages 2..PIPE_STAGES-1: register the sum, then carry it forward
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < N_MID; i++) begin
                        prod_q[i] <= '0;
                        mode_q[i] <= 2'b00;
                    end
                    valid_q <= '0;
                end else if (M_en) begin
                    prod_q[0]  <= sum_full;
                    mode_q[0]  <= s1_mode;
                    valid_q[0] <= s1_valid;
                    for (int i = 1; i < N_MID; i++) begin
                        prod_q[i]  <= prod_q[i-1];
                        mode_q[i]  <= mode_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign fin_prod  = prod_q[N_MID-1];
            assign fin_mode  = mode_q[N_MID-1];
            assign fin_valid = valid_q[N_MID-1];
            assign mid_busy  = |valid_q;
        end
    endgenerate

    // Final stage: select the product half; this register drives M_result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            M_result <= '0;
            M_valid  <= 1'b0;
        end else if (M_en) begin
            M_result <= (fin_mode == 2'b00) ? fin_prod[DATA_W-1:0] : fin_prod[PROD_W-1:DATA_W];
            M_valid  <= fin_valid;
        end
    end

    // Busy while any stage, including the output stage, holds a valid op
    assign M_busy = s1_valid | mid_busy | M_valid;

endmodule

// File: tb/tb_nios2_mult_pipe_cell.sv
// Directed and random bench for nios2_mult_pipe_cell (DATA_W=32, 3 stages).
module tb_nios2_mult_pipe_cell;

    localparam int DATA_W = 32;
    localparam int PS     = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] E_src1, E_src2;
    logic [1:0]        E_mode;
    logic              E_valid, M_en;
    logic [DATA_W-1:0] M_result;
    logic              M_valid, M_busy;

    int n_total = 0;
    int n_pass  = 0;
    int en_edges = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                due_q[$];
    logic              last_v = 1'b0;
    logic [DATA_W-1:0] last_r = '0;

    nios2_mult_pipe_cell #(.DATA_W(DATA_W), .PIPE_STAGES(PS)) dut (
        .clk(clk), .reset_n(reset_n),
        .E_src1(E_src1), .E_src2(E_src2), .E_mode(E_mode), .E_valid(E_valid),
        .M_en(M_en), .M_result(M_result), .M_valid(M_valid), .M_busy(M_busy)
    );

    // clock
    always #5 clk = ~clk;

    // reference product straight from the extension rules
    function automatic logic [DATA_W-1:0] ref_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                  input logic [1:0] m);
        logic [2*DATA_W-1:0] ea, eb, p;
        ea = (m == 2'b01 || m == 2'b10) ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        eb = (m == 2'b01) ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        p  = ea * eb;
        return (m == 2'b00) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
    endtask

    // drive one cycle, advance the scoreboard, check outputs 1 time unit after the edge
    task automatic cycle(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [1:0] m,
                         input logic v, input logic en);
        logic              exp_v;
        logic [DATA_W-1:0] exp_r;
        E_src1 = a; E_src2 = b; E_mode = m; E_valid = v; M_en = en;
        @(posedge clk);
        if (en) begin
            en_edges++;
            if (v) begin
                exp_q.push_back(ref_mul(a, b, m));
                due_q.push_back(en_edges + PS - 1);
            end
            if (due_q.size() > 0 && due_q[0] == en_edges) begin
                exp_v = 1'b1;
                exp_r = exp_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                exp_v = 1'b0;
                exp_r = last_r;
            end
        end else begin
            exp_v = last_v;
            exp_r = last_r;
        end
        last_v = exp_v;
        last_r = exp_r;
        #1;
        check_bit("m_valid", M_valid, exp_v);
        if (exp_v) check("m_result", M_result, exp_r);
        check_bit("m_busy", M_busy, exp_v || (exp_q.size() != 0));
    endtask

    task automatic idle(input logic en);
        cycle('0, '0, 2'b00, 1'b0, en);
    endtask

    // issue one op, wait out the latency, compare against a hand value
    task automatic run_one(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [1:0] m, input logic [DATA_W-1:0] hand);
        cycle(a, b, m, 1'b1, 1'b1);
        for (int i = 0; i < PS - 1; i++) idle(1'b1);
        check_bit({tag, "_valid"}, M_valid, 1'b1);
        check(tag, M_result, hand);
    endtask

    function automatic logic [DATA_W-1:0] pick_operand();
        logic [DATA_W-1:0] corners [5];
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        reset_n = 1'b0;
        E_src1 = '0; E_src2 = '0; E_mode = 2'b00; E_valid = 1'b0; M_en = 1'b0;
        #7;
        check_bit("rst_valid", M_valid, 1'b0);
        check_bit("rst_busy", M_busy, 1'b0);
        check("rst_result", M_result, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // T1 mul, latency is covered by the per-cycle valid checks
        run_one("t1_mul", 32'h0000_1234, 32'h0000_5678, 2'b00, 32'h0626_0060);

        // T2 sign handling of the high half
        run_one("t2_ss", 32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 32'hFFFF_FFFF);
        run_one("t2_uu", 32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 32'h0000_0001);
        run_one("t2_su", 32'hFFFF_FFFF, 32'h0000_0002, 2'b10, 32'hFFFF_FFFF);

        // T3 most-negative corners
        run_one("t3_ss", 32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000);
        run_one("t3_lo", 32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000);
        run_one("t3_su", 32'h8000_0000, 32'h8000_0000, 2'b10, 32'hC000_0000);

        // T4 three back-to-back mixed-mode ops, then a 5-cycle stall mid-flight
        cycle(32'h8000_0000, 32'h8000_0000, 2'b01, 1'b1, 1'b1);
        cycle(32'h0000_1234, 32'h0000_5678, 2'b00, 1'b1, 1'b1);
        cycle(32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 1'b1, 1'b1);
        check("t4_first", M_result, 32'h4000_0000);
        for (int i = 0; i < 5; i++) cycle($urandom, $urandom, 2'b01, 1'b1, 1'b0);
        check("t4_hold", M_result, 32'h4000_0000);
        idle(1'b1);
        check("t4_second", M_result, 32'h0626_0060);
        idle(1'b1);
        check("t4_third", M_result, 32'h0000_0001);
        idle(1'b1);
        check_bit("t4_no_dup", M_valid, 1'b0);

        // T5 asynchronous reset between edges with two ops in flight
        cycle(32'h0000_0003, 32'h0000_0005, 2'b00, 1'b1, 1'b1);
        cycle(32'h0000_0007, 32'h0000_0009, 2'b00, 1'b1, 1'b1);
        cycle(32'h0000_000B, 32'h0000_000D, 2'b00, 1'b1, 1'b0);
        reset_n = 1'b0;
        #2;
        check_bit("t5_valid", M_valid, 1'b0);
        check_bit("t5_busy", M_busy, 1'b0);
        check("t5_result", M_result, '0);
        exp_q.delete();
        due_q.delete();
        last_v = 1'b0;
        last_r = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < PS + 2; i++) idle(1'b1);
        run_one("t5_after", 32'h0000_0003, 32'h0000_0005, 2'b00, 32'h0000_000F);

        // T6 random operands, modes, bubbles and stalls against the reference
        for (int i = 0; i < 10000; i++) begin
            cycle(pick_operand(), pick_operand(), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
        end
        for (int i = 0; i < PS; i++) idle(1'b1);
        check("drain_empty", DATA_W'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
